// File: rtl/turn_sched_m_if.sv
// -----------------------------------------------------------------------------
// turn_sched_m_if
//   Move-bus bundle between the turn scheduler, the two move generators
//   (player and AI) and the board.
//
//   Handshake: p_submit / ai_submit are valid-only strobes. There is no
//   separate ready signal. The scheduler's `turn` output is the grant, and a
//   submit is consumed only when the scheduler is in its grant phase and
//   `turn` selects that side. A legal consumed move produces wr_en one cycle
//   later. An illegal one produces reject one cycle later. Any submit from
//   the side that does not hold the turn is dropped silently.
//
//   Signals (direction as seen from the scheduler, modport slave):
//     start       in   begin new game
//     p_loc       in   player cell index 0..8
//     p_submit    in   player move valid
//     p_reset     in   player game-restart request
//     ai_loc      in   AI cell index 0..8
//     ai_submit   in   AI move valid
//     occupied    in   board occupancy, bit i = cell i
//     game_over   in   board win/draw detect, valid the cycle after a write
//     turn        out  active side (0 player, 1 AI)
//     wr_en       out  one-cycle board write strobe
//     wr_loc      out  cell written, valid with wr_en
//     wr_mark     out  mark written, valid with wr_en
//     board_clr   out  one-cycle board clear pulse
//     reject      out  one-cycle illegal-move pulse
//     timeout     out  one-cycle forfeit pulse
//     forfeit     out  level, game ended by timeout
//     done        out  level, game finished
//     move_count  out  legal moves committed this game
// -----------------------------------------------------------------------------
interface turn_sched_m_if;
  logic       start;
  logic [3:0] p_loc;
  logic       p_submit;
  logic       p_reset;
  logic [3:0] ai_loc;
  logic       ai_submit;
  logic [8:0] occupied;
  logic       game_over;
  logic       turn;
  logic       wr_en;
  logic [3:0] wr_loc;
  logic       wr_mark;
  logic       board_clr;
  logic       reject;
  logic       timeout;
  logic       forfeit;
  logic       done;
  logic [3:0] move_count;

  // Scheduler side
  modport slave (
    input  start, p_loc, p_submit, p_reset, ai_loc, ai_submit, occupied, game_over,
    output turn, wr_en, wr_loc, wr_mark, board_clr, reject, timeout, forfeit,
           done, move_count
  );

  // Generator / board / bench side
  modport master (
    output start, p_loc, p_submit, p_reset, ai_loc, ai_submit, occupied, game_over,
    input  turn, wr_en, wr_loc, wr_mark, board_clr, reject, timeout, forfeit,
           done, move_count
  );
endinterface

// File: rtl/turn_sched_m.sv
// -----------------------------------------------------------------------------
// turn_sched_m
//   Turn scheduler for the tic-tac-toe datapath. It owns the turn flag,
//   validates the active side's move against board occupancy, and issues one
//   write strobe per legal move. It also counts moves, ends the game on board
//   win/draw or after nine moves, and forfeits a side that holds the turn for
//   TIMEOUT_CYCLES grant cycles without a legal submit.
//
//   Parameters:
//     TIMEOUT_CYCLES  grant cycles allowed per turn (1..255)
//     FIRST_TURN      side granted first (0 player, 1 AI)
//
//   Ports:
//     clk      in   clock, all state on rising edge
//     rst_n    in   asynchronous active-low reset
//     bus      --   move bus (turn_sched_m_if.slave)
//     o_state  out  current FSM state encoding, for observation
//                   (0 IDLE, 1 CLEAR, 2 GRANT, 3 WRITE, 4 SETTLE, 5 DONE)
// -----------------------------------------------------------------------------
module turn_sched_m #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int FIRST_TURN     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  turn_sched_m_if.slave        bus,
  output logic [2:0]           o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_GRANT  = 3'd2,
    S_WRITE  = 3'd3,
    S_SETTLE = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [7:0] TO_LOAD    = 8'(TIMEOUT_CYCLES);
  localparam logic       FIRST_SIDE = 1'(FIRST_TURN);
  localparam logic [3:0] MAX_MOVES  = 4'd9;

  state_e      r_state;
  state_e      w_state_nxt;

  logic        r_turn;
  logic [3:0]  r_loc;
  logic [3:0]  r_move_count;
  logic [7:0]  r_timer;
  logic        r_reject;
  logic        r_timeout;
  logic        r_forfeit;
  logic        r_done;

  logic        w_sub;
  logic [3:0]  w_loc;
  logic [15:0] w_occ_ext;
  logic        w_legal;
  logic        w_accept;
  logic        w_reject;
  logic        w_expire;
  logic        w_finish;
  logic        w_toggle;
  logic        w_enter_grant;
  logic        w_wr_en;

  // Only the side holding the turn is looked at; the other side's submit
  // never reaches the legality check.
  assign w_sub = r_turn ? bus.ai_submit : bus.p_submit;
  assign w_loc = r_turn ? bus.ai_loc    : bus.p_loc;

  // Cells 9..15 do not exist; padding them as occupied keeps the lookup
  // in range and makes out-of-range locations illegal for free.
  assign w_occ_ext = {7'h7f, bus.occupied};
  assign w_legal   = (w_loc <= 4'd8) && !w_occ_ext[w_loc];

  // ---------------------------------------------------------------------------
  // Next-state and event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_expire    = 1'b0;
    w_finish    = 1'b0;
    w_toggle    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        // A legal move on the last timer cycle still counts as a move.
        if (w_sub && w_legal) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WRITE;
        end else begin
          if (w_sub) w_reject = 1'b1;
          if (r_timer <= 8'd1) begin
            w_expire    = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_WRITE: begin
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        // r_move_count already includes the move written last cycle.
        if (bus.game_over || (r_move_count == MAX_MOVES)) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_toggle    = 1'b1;
          w_state_nxt = S_GRANT;
        end
      end
      S_DONE: begin
        if (bus.start) w_state_nxt = S_CLEAR;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Restart request overrides every other event outside IDLE, including a
    // legal submit sampled on the same edge.
    if (bus.p_reset && (r_state != S_IDLE)) begin
      w_state_nxt = S_CLEAR;
      w_accept    = 1'b0;
      w_reject    = 1'b0;
      w_expire    = 1'b0;
      w_finish    = 1'b0;
      w_toggle    = 1'b0;
    end
  end

  assign w_enter_grant = (w_state_nxt == S_GRANT) && (r_state != S_GRANT);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_turn       <= FIRST_SIDE;
      r_loc        <= 4'd0;
      r_move_count <= 4'd0;
      r_timer      <= 8'd0;
      r_reject     <= 1'b0;
      r_timeout    <= 1'b0;
      r_forfeit    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_reject  <= w_reject;
      r_timeout <= w_expire;

      // Game state is cleared on the edge that enters CLEAR, so the CLEAR
      // cycle already shows a fresh game alongside board_clr.
      if (w_state_nxt == S_CLEAR) begin
        r_move_count <= 4'd0;
        r_turn       <= FIRST_SIDE;
        r_forfeit    <= 1'b0;
        r_done       <= 1'b0;
      end else begin
        if (w_toggle) r_turn <= ~r_turn;
        if ((r_state == S_WRITE) && (r_move_count != MAX_MOVES)) begin
          r_move_count <= r_move_count + 4'd1;
        end
        if (w_expire) begin
          r_forfeit <= 1'b1;
          r_done    <= 1'b1;
        end
        if (w_finish) r_done <= 1'b1;
      end

      if (w_accept) r_loc <= w_loc;

      // Illegal submits do not reload the timer; only a fresh grant does.
      if (w_enter_grant) begin
        r_timer <= TO_LOAD;
      end else if (r_state == S_GRANT) begin
        r_timer <= r_timer - 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The write strobe follows the WRITE state even if a restart arrives in the
  // same cycle, so an in-flight write always completes.
  assign w_wr_en        = (r_state == S_WRITE);
  assign bus.wr_en      = w_wr_en;
  assign bus.wr_loc     = w_wr_en ? r_loc : 4'd0;
  assign bus.wr_mark    = w_wr_en & r_turn;
  assign bus.board_clr  = (r_state == S_CLEAR);
  assign bus.turn       = r_turn;
  assign bus.reject     = r_reject;
  assign bus.timeout    = r_timeout;
  assign bus.forfeit    = r_forfeit;
  assign bus.done       = r_done;
  assign bus.move_count = r_move_count;
  assign o_state        = r_state;

endmodule
